seg_disp_arbiter: RTL and testbench



---
 rtl/seg_disp_arbiter.sv | 170 +++++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing seven 7-segment displays between two frame requesters.
// Optional blinking digits are enabled with the SEG_DISP_BLINK_EN macro.
module seg_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [27:0] data_a,
  input  logic [6:0]  blank_a,
  input  logic        req_b,
  input  logic [27:0] data_b,
  input  logic [6:0]  blank_b,
`ifdef SEG_DISP_BLINK_EN
  input  logic [6:0]  blink_a,
  input  logic [6:0]  blink_b,
`endif
  output logic        ack_a,
  output logic        ack_b,
  output logic [1:0]  owner,
  output logic [1:0]  fsm_state,
  output logic [6:0]  seg_disp_0,
  output logic [6:0]  seg_disp_1,
  output logic [6:0]  seg_disp_2,
  output logic [6:0]  seg_disp_3,
  output logic [6:0]  seg_disp_4,
  output logic [6:0]  seg_disp_5,
  output logic [6:0]  seg_disp_6
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FREE  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  logic [1:0]  state;
  logic [31:0] hold_cnt;
  logic        last_grant_b;
  logic [27:0] data_q;
  logic [6:0]  blank_q;
  logic        req_a_v, req_b_v;
  logic        grant_a, grant_b, new_grant;
  logic [6:0]  disp [7];

  // Handshake: a requester holds req and its frame until ack pulses for one
  // cycle; req seen during that ack cycle is ignored, so one req yields one ack.
  always_comb begin
    req_a_v   = req_a & ~ack_a;
    req_b_v   = req_b & ~ack_b;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    new_grant = 1'b0;
    if (state == ST_HOLD) begin
      // Only the owner may refresh while the hold time runs.
      grant_a = req_a_v && (owner == OWN_A);
      grant_b = req_b_v && (owner == OWN_B);
    end else begin
      if (req_a_v && req_b_v) begin
        grant_a = last_grant_b;
        grant_b = ~last_grant_b;
      end else begin
        grant_a = req_a_v;
        grant_b = req_b_v;
      end
      new_grant = grant_a | grant_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_NONE;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      hold_cnt     <= 32'd0;
      last_grant_b <= 1'b1;
      data_q       <= 28'd0;
      blank_q      <= 7'h7F;
    end else begin
      ack_a <= grant_a;
      ack_b <= grant_b;
      if (grant_a) begin
        owner   <= OWN_A;
        data_q  <= data_a;
        blank_q <= blank_a;
      end else if (grant_b) begin
        owner   <= OWN_B;
        data_q  <= data_b;
        blank_q <= blank_b;
      end
      if (new_grant) begin
        last_grant_b <= grant_b;
        hold_cnt     <= HOLD_CYCLES - 32'd1;
        state        <= (HOLD_CYCLES == 32'd1) ? ST_FREE : ST_HOLD;
      end else if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt - 32'd1;
        if (hold_cnt == 32'd1) state <= ST_FREE;
      end
    end
  end

`ifdef SEG_DISP_BLINK_EN
  logic [6:0]  blink_q;
  logic [31:0] blink_cnt;
  logic        blink_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q   <= 7'h00;
      blink_cnt <= 32'd0;
      blink_on  <= 1'b1;
    end else begin
      if (grant_a) blink_q <= blink_a;
      else if (grant_b) blink_q <= blink_b;
      if (blink_cnt == BLINK_CYCLES - 32'd1) begin
        blink_cnt <= 32'd0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      disp[i] = hex_to_seg(data_q[4*i +: 4]);
      if (blank_q[i]) disp[i] = 7'h7F;
`ifdef SEG_DISP_BLINK_EN
      else if (!blink_on && blink_q[i]) disp[i] = 7'h7F;
`endif
    end
  end

  assign fsm_state  = state;
  assign seg_disp_0 = disp[0];
  assign seg_disp_1 = disp[1];
  assign seg_disp_2 = disp[2];
  assign seg_disp_3 = disp[3];
  assign seg_disp_4 = disp[4];
  assign seg_disp_5 = disp[5];
  assign seg_disp_6 = disp[6];

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: ownership/deadline model plus directed scenarios.
// Blink scenario is compiled in when SEG_DISP_BLINK_EN is defined.
module tb_seg_disp_arbiter;

  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a, req_b;
  logic [27:0] data_a, data_b;
  logic [6:0]  blank_a, blank_b;
  logic [6:0]  blink_a, blink_b;
  logic        ack_a, ack_b;
  logic [1:0]  owner, fsm_state;
  logic [6:0]  seg_disp_0, seg_disp_1, seg_disp_2, seg_disp_3;
  logic [6:0]  seg_disp_4, seg_disp_5, seg_disp_6;
  logic [6:0]  dut_seg [7];

  seg_disp_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .blank_a(blank_a),
    .req_b(req_b), .data_b(data_b), .blank_b(blank_b),
`ifdef SEG_DISP_BLINK_EN
    .blink_a(blink_a), .blink_b(blink_b),
`endif
    .ack_a(ack_a), .ack_b(ack_b), .owner(owner), .fsm_state(fsm_state),
    .seg_disp_0(seg_disp_0), .seg_disp_1(seg_disp_1), .seg_disp_2(seg_disp_2),
    .seg_disp_3(seg_disp_3), .seg_disp_4(seg_disp_4), .seg_disp_5(seg_disp_5),
    .seg_disp_6(seg_disp_6)
  );

  assign dut_seg[0] = seg_disp_0;
  assign dut_seg[1] = seg_disp_1;
  assign dut_seg[2] = seg_disp_2;
  assign dut_seg[3] = seg_disp_3;
  assign dut_seg[4] = seg_disp_4;
  assign dut_seg[5] = seg_disp_5;
  assign dut_seg[6] = seg_disp_6;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // model: ownership with an absolute deadline in clock edges since reset
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic        m_ack_a, m_ack_b, m_last_b;
  logic [1:0]  m_owner;
  logic [27:0] m_data;
  logic [6:0]  m_blank, m_blink;
  int          edge_cnt, m_hold_end;

  always @(posedge clk) begin
    logic ra, rb, ga, gb;
    if (reset) begin
      m_ack_a = 0; m_ack_b = 0; m_last_b = 1; m_owner = 0;
      m_data = 0; m_blank = 7'h7F; m_blink = 0;
      edge_cnt = 0; m_hold_end = 0;
    end else begin
      edge_cnt++;
      ra = req_a && !m_ack_a;
      rb = req_b && !m_ack_b;
      if (m_owner == 0 || edge_cnt >= m_hold_end) begin
        if (ra && rb) begin ga = m_last_b; gb = !m_last_b; end
        else begin ga = ra; gb = rb; end
        if (ga || gb) begin
          m_hold_end = edge_cnt + HOLD;
          m_last_b   = gb;
        end
      end else begin
        ga = ra && (m_owner == 1);
        gb = rb && (m_owner == 2);
      end
      if (ga) begin m_owner = 1; m_data = data_a; m_blank = blank_a; m_blink = blink_a; end
      else if (gb) begin m_owner = 2; m_data = data_b; m_blank = blank_b; m_blink = blink_b; end
      m_ack_a = ga;
      m_ack_b = gb;
    end
  end

  function automatic logic [6:0] exp_seg(input int i);
    logic blink_off;
`ifdef SEG_DISP_BLINK_EN
    blink_off = ((edge_cnt / BLINK) % 2) == 1;
`else
    blink_off = 1'b0;
`endif
    if (m_blank[i] || (blink_off && m_blink[i])) return 7'h7F;
    return seg_tab[m_data[4*i +: 4]];
  endfunction

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ack_a", ack_a, m_ack_a);
      chk("cyc_ack_b", ack_b, m_ack_b);
      chk("cyc_owner", owner, m_owner);
      for (int i = 0; i < 7; i++) chk($sformatf("cyc_seg%0d", i), dut_seg[i], exp_seg(i));
    end
  end

  // driver helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] t1_exp [7] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  int         alt_exp [4] = '{1, 2, 1, 2};

  initial begin
    int wait_n;
    logic [1:0] prev;
    reset = 1; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
    blank_a = 0; blank_b = 0; blink_a = 0; blink_b = 0;
    tick(2);
    chk_en = 1;
    chk("rst_owner", owner, 2'b00);
    chk("rst_ack_a", ack_a, 1'b0);
    for (int i = 0; i < 7; i++) chk($sformatf("rst_seg%0d", i), dut_seg[i], 7'h7F);

    // first grant to A
    reset = 0; req_a = 1; data_a = 28'h6543210; blank_a = 0;
    tick(1);
    chk("t1_ack_a", ack_a, 1'b1);
    chk("t1_owner", owner, 2'b01);
    for (int i = 0; i < 7; i++) chk($sformatf("t1_seg%0d", i), dut_seg[i], t1_exp[i]);
    chk("model_t1_seg0", exp_seg(0), 7'h40);
    req_a = 0;
    tick(1);
    chk("t1_ack_pulse", ack_a, 1'b0);

    // B waits out A's hold
    req_b = 1; data_b = 28'hFFFFFFF; blank_b = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("t2_no_ack_b", ack_b, 1'b0);
      chk("t2_owner_a", owner, 2'b01);
    end
    tick(1);
    chk("t2_ack_b", ack_b, 1'b1);
    chk("t2_owner_b", owner, 2'b10);
    for (int i = 0; i < 7; i++) chk($sformatf("t2_seg%0d", i), dut_seg[i], 7'h0E);
    chk("model_t2_owner", m_owner, 2'b10);
    req_b = 0;

    // reset mid-hold
    tick(1);
    reset = 1;
    tick(1);
    chk("mid_rst_owner", owner, 2'b00);
    chk("mid_rst_ack_b", ack_b, 1'b0);
    for (int i = 0; i < 7; i++) chk($sformatf("mid_rst_seg%0d", i), dut_seg[i], 7'h7F);

    // both requesting from reset: strict alternation
    reset = 0; req_a = 1; req_b = 1; data_a = 28'h6543210; data_b = 28'hFFFFFFF;
    prev = 2'b00;
    for (int g = 0; g < 4; g++) begin
      wait_n = 0;
      while (wait_n < 20) begin
        tick(1);
        wait_n++;
        if (owner != prev) break;
      end
      chk($sformatf("alt_owner%0d", g), owner, alt_exp[g]);
      chk($sformatf("alt_gap%0d", g), wait_n, (g == 0) ? 1 : HOLD);
      prev = owner;
    end
    req_a = 0; req_b = 0;

    // owner refresh during hold, B blocked until original expiry
    reset = 1;
    tick(1);
    reset = 0; req_a = 1; data_a = 28'h6543210; blank_a = 0;
    tick(1);
    chk("rf_ack_a", ack_a, 1'b1);
    req_a = 0; req_b = 1; data_b = 28'h0123456; blank_b = 0;
    tick(2);
    req_a = 1; data_a = 28'h6543218;
    tick(1);
    chk("rf_ack_a2", ack_a, 1'b1);
    chk("rf_seg0", seg_disp_0, 7'h00);
    chk("rf_ack_b_blocked", ack_b, 1'b0);
    req_a = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("rf_no_ack_b", ack_b, 1'b0);
    end
    tick(1);
    chk("rf_ack_b", ack_b, 1'b1);
    chk("rf_owner_b", owner, 2'b10);
    chk("rf_seg0_b", seg_disp_0, 7'h02);
    req_b = 0;

    // fully blanked frame
    req_a = 1; data_a = 28'h9ABCDEF; blank_a = 7'h7F;
    wait_n = 0;
    while (wait_n < 20) begin
      tick(1);
      wait_n++;
      if (ack_a) break;
    end
    chk("bl_wait", wait_n, HOLD);
    chk("bl_owner", owner, 2'b01);
    for (int i = 0; i < 7; i++) chk($sformatf("bl_seg%0d", i), dut_seg[i], 7'h7F);
    req_a = 0; blank_a = 0;

`ifdef SEG_DISP_BLINK_EN
    reset = 1;
    tick(1);
    reset = 0; req_a = 1; data_a = 28'h6543210; blink_a = 7'h01;
    tick(1);
    chk("bk_seg0_on", seg_disp_0, 7'h40);
    req_a = 0;
    tick(3);
    chk("bk_seg0_off", seg_disp_0, 7'h7F);
    chk("bk_seg1_static", seg_disp_1, 7'h79);
    tick(4);
    chk("bk_seg0_on2", seg_disp_0, 7'h40);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
